// File: rtl/mem_byte_ctrl.sv
// Byte-serial bridge between the cache request port and the 8-bit RAM/IO bus.
// Loads and stores of 1, 2 or 4 bytes run one byte per cycle; load data is little-endian and extended.
module mem_byte_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        valid,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [2:0]  len,
  input  logic [31:0] data,
  output logic        ready,
  output logic [31:0] res
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic [2:0]  req_len_reg, req_len_next;
  logic [31:0] req_data_reg, req_data_next;
  logic        abort_reg, abort_next;
  logic [31:0] rbuf_reg, rbuf_next;
  logic [31:0] mem_a_reg, mem_a_next;
  logic [7:0]  mem_dout_reg, mem_dout_next;
  logic        ready_reg, ready_next;
  logic [31:0] res_reg, res_next;

  logic [2:0]  n_bytes;
  logic [2:0]  step;
  logic [1:0]  rd_idx;
  logic [31:0] rbuf_merged;
  logic [31:0] rd_ext;
  logic        stall;

  // step is the edge index relative to acceptance (E1, E2, ...) when taken at this edge
  assign n_bytes = (req_len_reg[1:0] == 2'd0) ? 3'd1 :
                   (req_len_reg[1:0] == 2'd1) ? 3'd2 : 3'd4;
  assign step    = cnt_reg + 3'd1;
  assign rd_idx  = step[1:0] - 2'd2;
  assign stall   = (state_reg == WRITE) && (mem_a_reg >= IO_BASE) && io_buffer_full;

  assign mem_a    = mem_a_reg;
  assign mem_dout = mem_dout_reg;
  assign mem_wr   = (state_reg == WRITE) && !stall;
  assign ready    = ready_reg;
  assign res      = res_reg;

  always_comb begin
    rbuf_merged = rbuf_reg;
    rbuf_merged[{rd_idx, 3'b000} +: 8] = mem_din;
  end

  // len[2] selects zero extension for the sub-word loads
  always_comb begin
    if (req_len_reg[1]) begin
      rd_ext = rbuf_merged;
    end else if (req_len_reg[0]) begin
      rd_ext = {{16{rbuf_merged[15] & ~req_len_reg[2]}}, rbuf_merged[15:0]};
    end else begin
      rd_ext = {{24{rbuf_merged[7] & ~req_len_reg[2]}}, rbuf_merged[7:0]};
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    req_addr_next = req_addr_reg;
    req_len_next  = req_len_reg;
    req_data_next = req_data_reg;
    abort_next    = abort_reg;
    rbuf_next     = rbuf_reg;
    mem_a_next    = mem_a_reg;
    mem_dout_next = mem_dout_reg;
    ready_next    = 1'b0;
    res_next      = res_reg;
    case (state_reg)
      IDLE: begin
        mem_a_next    = 32'd0;
        mem_dout_next = 8'd0;
        if (valid) begin
          req_addr_next = addr;
          req_len_next  = len;
          req_data_next = data;
          cnt_next      = 3'd0;
          abort_next    = 1'b0;
          rbuf_next     = 32'd0;
          mem_a_next    = addr;
          if (wr) begin
            state_next    = WRITE;
            mem_dout_next = data[7:0];
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        if (!valid) begin
          state_next = IDLE;
          mem_a_next = 32'd0;
        end else begin
          cnt_next = step;
          if (step < n_bytes) begin
            mem_a_next = req_addr_reg + {29'd0, step};
          end
          // RAM returns a byte one cycle after its address, so captures trail issue by two edges
          if (step >= 3'd2) begin
            rbuf_next = rbuf_merged;
          end
          if (step == n_bytes + 3'd1) begin
            state_next = DONE;
            ready_next = 1'b1;
            res_next   = rd_ext;
            mem_a_next = 32'd0;
          end
        end
      end
      WRITE: begin
        abort_next = abort_reg | ~valid;
        if (!stall) begin
          cnt_next = step;
          if (step == n_bytes) begin
            mem_a_next    = 32'd0;
            mem_dout_next = 8'd0;
            res_next      = 32'd0;
            if (abort_reg || !valid) begin
              state_next = IDLE;
            end else begin
              state_next = DONE;
              ready_next = 1'b1;
            end
          end else begin
            mem_a_next    = req_addr_reg + {29'd0, step};
            mem_dout_next = req_data_reg[{step[1:0], 3'b000} +: 8];
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      req_addr_reg <= 32'd0;
      req_len_reg  <= 3'd0;
      req_data_reg <= 32'd0;
      abort_reg    <= 1'b0;
      rbuf_reg     <= 32'd0;
      mem_a_reg    <= 32'd0;
      mem_dout_reg <= 8'd0;
      ready_reg    <= 1'b0;
      res_reg      <= 32'd0;
    end else if (rdy_in) begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      req_addr_reg <= req_addr_next;
      req_len_reg  <= req_len_next;
      req_data_reg <= req_data_next;
      abort_reg    <= abort_next;
      rbuf_reg     <= rbuf_next;
      mem_a_reg    <= mem_a_next;
      mem_dout_reg <= mem_dout_next;
      ready_reg    <= ready_next;
      res_reg      <= res_next;
    end
  end

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Directed bench for mem_byte_ctrl: a RAM model on the byte bus and scoreboard queues
// for completions and bus writes, drained by a monitor on the falling edge.
module tb_mem_byte_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        valid = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [2:0]  len = 3'd0;
  logic [31:0] data = 32'd0;
  logic        ready;
  logic [31:0] res;

  mem_byte_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .valid(valid), .wr(wr), .addr(addr), .len(len), .data(data),
    .ready(ready), .res(res)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [31:0] res; int cyc; string name; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wexp_t;

  exp_t  exp_q[$];
  wexp_t wq[$];
  int    vectors = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    issue_cyc = 0;
  logic [7:0] ram [0:262143];

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // monitor: every completion and every bus write must match the head of its queue
  always @(negedge clk_in) begin : monitor
    exp_t  e;
    wexp_t w;
    if (rst_in) begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_ready: got ready with res=%h, required no ready", res);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_res"}, res, e.res);
          check({e.name, "_lat"}, cyc, e.cyc);
          $display("txn %s: res=%h cycle=%0d", e.name, res, cyc);
        end
      end
      if (mem_wr) begin
        if (wq.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_write: got a=%h d=%h, required no write", mem_a, mem_dout);
        end else begin
          w = wq.pop_front();
          check("wr_addr", mem_a, w.a);
          check("wr_data", {24'd0, mem_dout}, {24'd0, w.d});
          $display("bus write a=%h d=%h", mem_a, mem_dout);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] l, input logic [31:0] d);
    @(posedge clk_in); #1;
    valid = 1'b1; wr = w; addr = a; len = l; data = d;
    issue_cyc = cyc;
  endtask

  task automatic expect_done(input logic [31:0] r, input int lat, input string name);
    exp_t e;
    e.res = r; e.cyc = issue_cyc + 1 + lat; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [7:0] d);
    wexp_t w;
    w.a = a; w.d = d;
    wq.push_back(w);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk_in); #1;
      if (ready) seen = 1'b1;
    end
    valid = 1'b0;
    if (!seen) begin
      vectors++; errors++;
      $display("FAIL %s_timeout: got no ready in 40 cycles, required ready", name);
      exp_q.delete();
      wq.delete();
    end
  endtask

  initial begin
    ram[18'h100] = 8'h11; ram[18'h101] = 8'h22; ram[18'h102] = 8'h33; ram[18'h103] = 8'h84;
    ram[18'h104] = 8'h7E; ram[18'h200] = 8'hF0; ram[18'h303] = 8'h5A;
    ram[18'h400] = 8'hA0; ram[18'h401] = 8'hA5;

    #12;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    @(posedge clk_in); #1 rst_in = 1'b1;

    // word load with address sequence
    issue(1'b0, 32'h100, 3'b010, 32'd0);
    expect_done(32'h84332211, 5, "word_ld");
    @(posedge clk_in);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check($sformatf("word_ld_a%0d", k), mem_a, 32'h100 + k);
      @(posedge clk_in);
    end
    wait_done("word_ld");

    issue(1'b0, 32'h200, 3'b000, 32'd0);
    expect_done(32'hFFFFFFF0, 2, "byte_ld_sx");
    wait_done("byte_ld_sx");
    issue(1'b0, 32'h200, 3'b100, 32'd0);
    expect_done(32'h000000F0, 2, "byte_ld_zx");
    wait_done("byte_ld_zx");
    issue(1'b0, 32'h102, 3'b001, 32'd0);
    expect_done(32'hFFFF8433, 3, "half_ld_sx");
    wait_done("half_ld_sx");
    issue(1'b0, 32'h102, 3'b101, 32'd0);
    expect_done(32'h00008433, 3, "half_ld_zx");
    wait_done("half_ld_zx");
    issue(1'b0, 32'h101, 3'b011, 32'd0);
    expect_done(32'h7E843322, 5, "word_ld_unal");
    wait_done("word_ld_unal");

    // half store, odd address
    expect_wr(32'h301, 8'hDD); expect_wr(32'h302, 8'hCC);
    issue(1'b1, 32'h301, 3'b001, 32'hAABBCCDD);
    expect_done(32'd0, 2, "half_st");
    wait_done("half_st");
    @(posedge clk_in); #1;
    check("half_st_ram301", {24'd0, ram[18'h301]}, 32'hDD);
    check("half_st_ram302", {24'd0, ram[18'h302]}, 32'hCC);
    check("half_st_ram303", {24'd0, ram[18'h303]}, 32'h5A);

    // word store then read back
    expect_wr(32'h500, 8'hBE); expect_wr(32'h501, 8'hBA);
    expect_wr(32'h502, 8'hFE); expect_wr(32'h503, 8'hCA);
    issue(1'b1, 32'h500, 3'b010, 32'hCAFEBABE);
    expect_done(32'd0, 4, "word_st");
    wait_done("word_st");
    issue(1'b0, 32'h500, 3'b010, 32'd0);
    expect_done(32'hCAFEBABE, 5, "word_rb");
    wait_done("word_rb");

    // IO store held off by a full UART buffer for three cycles
    expect_wr(32'h30000, 8'h41);
    issue(1'b1, 32'h30000, 3'b000, 32'h00000041);
    io_buffer_full = 1'b1;
    expect_done(32'd0, 4, "io_st");
    @(posedge clk_in);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check($sformatf("io_stall%0d", k), {31'd0, mem_wr}, 32'd0);
      @(posedge clk_in);
    end
    #1 io_buffer_full = 1'b0;
    wait_done("io_st");
    @(posedge clk_in); #1;
    check("io_st_ram", {24'd0, ram[18'h30000]}, 32'h41);

    // aborted word load: no completion, bus released, next load correct
    issue(1'b0, 32'h100, 3'b010, 32'd0);
    @(posedge clk_in);
    @(posedge clk_in); #1 valid = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check("abort_mem_a", mem_a, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    repeat (3) @(posedge clk_in);
    issue(1'b0, 32'h200, 3'b100, 32'd0);
    expect_done(32'h000000F0, 2, "after_abort");
    wait_done("after_abort");

    // reset in the middle of a word store
    expect_wr(32'h400, 8'h04);
    issue(1'b1, 32'h400, 3'b010, 32'h01020304);
    @(posedge clk_in);
    @(posedge clk_in); #2;
    rst_in = 1'b0; valid = 1'b0;
    #1;
    check("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("midrst_mem_a", mem_a, 32'd0);
    check("midrst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    @(posedge clk_in); #1 rst_in = 1'b1;
    check("midrst_ram400", {24'd0, ram[18'h400]}, 32'h04);
    check("midrst_ram401", {24'd0, ram[18'h401]}, 32'hA5);
    issue(1'b0, 32'h100, 3'b000, 32'd0);
    expect_done(32'h00000011, 2, "after_rst");
    wait_done("after_rst");

    repeat (3) @(posedge clk_in);
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("wq_empty", wq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required completion");
    $fatal(1, "watchdog");
  end

endmodule
